ex_alu_unit: RTL and testbench

Execute-stage arithmetic unit of the multistage MIPS pipeline. It consumes the 4-bit ALU control code from the ALU-control stage plus the two operands and shift amount from the ID/EX register, and produces a registered result and zero flag for the EX/MEM stage. Single-cycle operations complete in one clock. SLL runs iteratively at one bit per clock under a small FSM, with valid/ready handshakes on both sides so the pipeline stalls while a shift is in flight.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_core.sv | 28 ++
 rtl/ex_alu_unit.sv | 102 ++++++++++
 tb/tb_ex_alu_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by ALU control and the EX stage,
// plus the EX-stage FSM state type.
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational evaluation of every single-cycle ALU operation.
// SLL and unknown codes produce zero here; SLL is sequenced by ex_alu_unit.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_ctrl)
      ALU_AND: y = src_a & src_b;
      ALU_OR:  y = src_a | src_b;
      ALU_ADD: y = src_a + src_b;
      ALU_XOR: y = src_a ^ src_b;
      ALU_LUI: y = src_b << 16;
      ALU_SUB: y = src_a - src_b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/ex_alu_unit.sv
// EX-stage ALU with registered result/zero, valid/ready handshakes and an
// iterative one-bit-per-clock SLL that stalls issue while shifting.
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       shamt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [WIDTH-1:0] result_d, core_y, shifted;
  logic [4:0]       cnt, cnt_d;
  logic             ov_d, zero_d, accept, is_sll;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctrl(alu_ctrl),
    .src_a   (src_a),
    .src_b   (src_b),
    .y       (core_y)
  );

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign is_sll   = (alu_ctrl == ALU_SLL);
  assign shifted  = shreg << 1;
  assign busy     = (state == SHIFT);
  assign zero_d   = (result_d == '0);

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    cnt_d    = cnt;
    result_d = result;
    ov_d     = out_valid;
    // A consumed result drops valid; a same-cycle load below re-raises it.
    if (out_valid && out_ready) ov_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_sll && (shamt != 5'd0)) begin
              shreg_d = src_b;
              cnt_d   = shamt;
              state_d = SHIFT;
            end else begin
              result_d = is_sll ? src_b : core_y;
              ov_d     = 1'b1;
            end
          end
        end
        SHIFT: begin
          shreg_d = shifted;
          cnt_d   = cnt - 5'd1;
          if (cnt == 5'd1) begin
            result_d = shifted;
            ov_d     = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      cnt       <= cnt_d;
      result    <= result_d;
      zero      <= zero_d;
      out_valid <= ov_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: directed corner cases then randomized ops
// with random downstream back-pressure, checked against an arithmetic model.
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  shamt;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  logic        rand_rdy = 1'b0;

  ex_alu_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .shamt    (shamt),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endfunction

  // Reference model: MIPS ALU semantics as plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] s);
    longint unsigned p;
    case (c)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return a ^ b;
      4'h5: return b * 32'd65536;
      4'h6: return a - b;
      4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: begin
        p = longint'(b) * (64'd1 << s);
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: sample just before each rising edge; a transfer happens when valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && !flush && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got result %h, required no output", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.r);
          chk("zero", 32'(zero), 32'(e.z));
        end
      end
    end
  end

  // Random downstream back-pressure, active only in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // All driver tasks are entered and left at 2 time units after a rising edge.
  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s, output int unsigned waited);
    exp_t e;
    waited   = 0;
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    shamt    = s;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      #4;
      if (in_ready && !flush) begin
        e.r = ref_alu(c, a, b, s);
        e.z = (e.r == 32'd0);
        sb.push_back(e);
        break;
      end
      waited++;
      if (waited > 200) begin
        checks++;
        $display("FAIL issue_timeout: got in_ready low for %0d cycles, required accept", waited);
        break;
      end
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned max);
    int unsigned n = 0;
    while (sb.size() != 0 && n < max) begin
      cyc(1);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int unsigned w, nb, bad, seen;
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [4:0]  s;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; src_a = '0; src_b = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // Single-cycle ops: one-edge latency.
    issue(4'h2, 32'h7FFF_FFFF, 32'h1, 5'd0, w);
    chk("add_latency_valid", 32'(out_valid), 1);
    issue(4'h6, 32'd5, 32'd5, 5'd0, w);
    issue(4'h7, 32'hFFFF_FFFF, 32'h1, 5'd0, w);
    issue(4'h5, 32'h0, 32'h0000_1234, 5'd0, w);
    issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, w);
    drain(10);

    // SLL by 31: busy for 31 cycles with issue blocked.
    issue(4'h8, 32'h0, 32'h1, 5'd31, w);
    nb = 0; bad = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      nb++;
      if (in_ready) bad++;
      cyc(1);
    end
    chk("sll31_busy_cycles", nb, 31);
    chk("sll31_in_ready_low", bad, 0);
    chk("sll31_out_valid", 32'(out_valid), 1);
    drain(10);
    issue(4'h8, 32'h0, 32'h1, 5'd0, w);
    chk("sll0_one_cycle", 32'(out_valid), 1);
    drain(10);

    // Back-to-back issue with the result consumed every cycle.
    issue(4'h2, 32'd100, 32'd23, 5'd0, w);
    issue(4'h1, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, w);
    chk("b2b_or_wait", w, 0);
    issue(4'h3, 32'hAAAA_5555, 32'hAAAA_5555, 5'd0, w);
    chk("b2b_xor_wait", w, 0);
    drain(10);

    // Stall: result must hold and a presented op must not be taken.
    issue(4'h2, 32'd40, 32'd2, 5'd0, w);
    out_ready = 1'b0;
    alu_ctrl = 4'h6; src_a = 32'd9; src_b = 32'd4; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (result !== 32'd42 || !out_valid || in_ready) bad++;
    end
    chk("stall_hold", bad, 0);
    out_ready = 1'b1;
    issue(4'h6, 32'd9, 32'd4, 5'd0, w);
    drain(10);

    // Flush in the 4th shifting cycle of SLL by 10.
    issue(4'h8, 32'h0, 32'h3, 5'd10, w);
    cyc(3);
    flush = 1'b1;
    @(negedge clk);
    #4;
    sb.delete();
    @(posedge clk);
    #2;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      if (out_valid) seen++;
    end
    chk("flush_no_output", seen, 0);

    // Flush with a same-cycle op: op is dropped.
    alu_ctrl = 4'h2; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    cyc(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid_not_taken", 32'(out_valid), 0);
    cyc(2);
    chk("flush_valid_quiet", 32'(out_valid), 0);

    // Reset while shifting.
    issue(4'h8, 32'h0, 32'h5, 5'd20, w);
    cyc(5);
    rst_n = 1'b0;
    sb.delete();
    cyc(1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_result", result, 0);
    chk("midrst_zero", 32'(zero), 1);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cyc(1);

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) c = 4'h8;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 3) == 0) s = 5'($urandom_range(0, 31));
      else s = 5'($urandom_range(0, 4));
      issue(c, a, b, s, w);
      if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    cyc(1);
    out_ready = 1'b1;
    drain(300);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
